// File: rtl/div_seq_pkg.sv
// Shared encodings for the sequential divider: FSM states, handshake levels
// and the operand width.
package div_seq_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// result = {remainder, quotient}; ready is held until the requester drops start.
module div_seq
    import div_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]     r_rem, w_rem_nxt;
    logic [DATA_W-1:0]     r_quo, w_quo_nxt;
    logic [DATA_W-1:0]     r_dvs, w_dvs_nxt;
    logic                  r_neg_q, w_neg_q_nxt;
    logic                  r_neg_r, w_neg_r_nxt;
    logic [2*DATA_W-1:0]   r_result, w_result_nxt;
    logic                  r_ready, w_ready_nxt;

    logic signed [DATA_W-1:0] w_op1_s, w_op2_s;
    logic                     w_op1_neg, w_op2_neg;
    logic [DATA_W-1:0]        w_abs1, w_abs2;
    logic [DATA_W:0]          w_shift;
    logic [DATA_W-1:0]        w_diff;
    logic                     w_fit;

    assign w_op1_s   = opdata1_i;
    assign w_op2_s   = opdata2_i;
    assign w_op1_neg = signed_div_i && (w_op1_s < 0);
    assign w_op2_neg = signed_div_i && (w_op2_s < 0);
    assign w_abs1    = w_op1_neg ? twos_neg(opdata1_i) : opdata1_i;
    assign w_abs2    = w_op2_neg ? twos_neg(opdata2_i) : opdata2_i;

    // Partial remainder stays below the divisor, so a fitting difference
    // always fits in DATA_W bits and the modular subtract is exact.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_fit   = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[DATA_W-1:0] - r_dvs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dvs    <= w_dvs_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dvs_nxt    = r_dvs;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;
        case (r_state)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt = DivOn;
                        w_cnt_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_quo_nxt   = w_abs1;
                        w_dvs_nxt   = w_abs2;
                        w_neg_q_nxt = w_op1_neg ^ w_op2_neg;
                        w_neg_r_nxt = w_op1_neg;
                    end
                end
            end
            DivByZero: begin
                w_result_nxt = '0;
                w_state_nxt  = annul_i ? DivFree : DivEnd;
                w_cnt_nxt    = '0;
                w_ready_nxt  = DivResultNotReady;
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_nxt  = DivFree;
                    w_cnt_nxt    = '0;
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultNotReady;
                end else if (r_cnt != CNT_W'(DATA_W)) begin
                    w_rem_nxt = w_fit ? w_diff : w_shift[DATA_W-1:0];
                    w_quo_nxt = {r_quo[DATA_W-2:0], w_fit};
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    // Quotient sign follows the operand signs, remainder follows the dividend.
                    w_result_nxt = {r_neg_r ? twos_neg(r_rem) : r_rem,
                                    r_neg_q ? twos_neg(r_quo) : r_quo};
                    w_ready_nxt  = DivResultReady;
                    w_state_nxt  = DivEnd;
                    w_cnt_nxt    = '0;
                end
            end
            DivEnd: begin
                if (start_i == DivStart) begin
                    w_ready_nxt = DivResultReady;
                end else begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: stimulus pushes expected results to a queue,
// a monitor pops and compares on every rising ready.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of ready carries one result.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_unexpected_ready actual=%h required=none", result);
                end else begin
                    chk("mon_result", result, exp_q.pop_front());
                end
            end
            prev = ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                           input int hold, input bit scramble);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        exp_q.push_back(exp);
        n    = 0;
        seen = 0;
        while (!seen && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (ready === 1'b1) seen = 1;
            else if (scramble) begin
                op1        = $urandom;
                op2        = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
        end
        chk({name, "_latency"}, 64'(n - 1), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_ready"}, {63'b0, ready}, 64'd1);
            chk({name, "_hold_result"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({name, "_drop_ready"}, {63'b0, ready}, 64'd0);
        chk({name, "_drop_result"}, result, 64'd0);
    endtask

    task automatic quiet_cycles(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) hits++;
        end
        chk(name, 64'(hits), 64'd0);
    endtask

    initial begin
        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'b0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        run_div("u100_7",   1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}, 33, 0, 0);
        run_div("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0, 0);
        run_div("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 33, 0, 0);
        run_div("s_m7_m2",  1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 33, 0, 0);
        run_div("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,        {32'h00000000, 32'hFFFFFFFF}, 33, 0, 0);
        run_div("u_5_10",   1'b0, 32'd5,          32'd10,       {32'h00000005, 32'h00000000}, 33, 0, 0);
        run_div("u_min_m1", 1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}, 33, 0, 0);
        run_div("div0",     1'b0, 32'h00001234,   32'd0,        64'd0,                         2, 0, 0);

        // Abort while cnt == 10: no result may appear.
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul_ready", {63'b0, ready}, 64'd0);
        chk("annul_result", result, 64'd0);
        quiet_cycles("annul_quiet", 40);
        run_div("u_9_3", 1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, 33, 0, 0);

        // Reset while cnt == 20.
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd5; start = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", {63'b0, ready}, 64'd0);
        chk("midrst_result", result, 64'd0);
        quiet_cycles("midrst_quiet", 40);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 33, 0, 0);

        // -1000 / 7 = -142 rem -6, operands scrambled after acceptance.
        run_div("scramble", 1'b1, 32'hFFFFFC18, 32'd7, {32'hFFFFFFFA, 32'hFFFFFF72}, 33, 5, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
